// File: rtl/tracker_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tracker_pkg: state encoding and defaults for tracking_counter |
// | Rev 1.0                                                       |
// +--------------------------------------------------------------+
package tracker_pkg;

  localparam int TRK_WIDTH = 4;
  localparam int TRK_HOLD  = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TRACK = 3'd1,
    HOLD  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } trk_state_e;

  // A healthy comparator asserts exactly one of its three relations.
  function automatic logic flags_one_hot(input logic agb, input logic alb, input logic aeb);
    return ({agb, alb, aeb} == 3'b100) || ({agb, alb, aeb} == 3'b010) ||
           ({agb, alb, aeb} == 3'b001);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tracking_counter.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tracking_counter: walks count toward target via comparator    |
// | flags, pulses done after HOLD_CYCLES of match. Rev 1.0         |
// +--------------------------------------------------------------+
module tracking_counter
  import tracker_pkg::*;
#(
  parameter int WIDTH       = TRK_WIDTH,
  parameter int HOLD_CYCLES = TRK_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] target_in,
  input  logic             AgB,
  input  logic             AlB,
  input  logic             AeB,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] target,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int HCW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  trk_state_e       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
  logic             flags_ok;

  assign flags_ok = flags_one_hot(AgB, AlB, AeB);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      target_q   <= '0;
      dir_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      target_q   <= target_d;
      dir_q      <= dir_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    target_d   = target_q;
    dir_d      = dir_q;
    hold_cnt_d = hold_cnt_q;

    unique case (state_q)
      IDLE, ERR: begin
        if (start) begin
          target_d   = target_in;
          hold_cnt_d = '0;
          state_d    = TRACK;
        end
      end
      TRACK: begin
        if (start) begin
          target_d   = target_in;
          hold_cnt_d = '0;
        end else if (!flags_ok) begin
          state_d = ERR;
        end else if (AlB) begin
          // Stepping past the end of the range is a fault, never a wrap.
          if (count_q == '1) begin
            state_d = ERR;
          end else begin
            count_d = count_q + WIDTH'(1);
            dir_d   = 1'b1;
          end
        end else if (AgB) begin
          if (count_q == '0) begin
            state_d = ERR;
          end else begin
            count_d = count_q - WIDTH'(1);
            dir_d   = 1'b0;
          end
        end else begin
          hold_cnt_d = '0;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (start) begin
          target_d   = target_in;
          hold_cnt_d = '0;
          state_d    = TRACK;
        end else if (!flags_ok) begin
          state_d = ERR;
        end else if (AeB) begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d = DONE;
          end else begin
            hold_cnt_d = hold_cnt_q + HCW'(1);
          end
        end else begin
          state_d = TRACK;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status flags are registered views of the next state, so they line up with it.
  always_comb begin
    busy_d = (state_d == TRACK) || (state_d == HOLD);
    done_d = (state_d == DONE);
    err_d  = (state_d == ERR);
  end

  assign count  = count_q;
  assign target = target_q;
  assign dir    = dir_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_tracking_counter.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tb_tracking_counter: closed-loop bench with behavioural        |
// | comparator and event scoreboard. Rev 1.0                       |
// +--------------------------------------------------------------+
module tb_tracking_counter;

  localparam int W = 4;
  localparam int H = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] target_in = '0;
  logic         AgB, AlB, AeB;
  logic [W-1:0] count, target;
  logic         dir, busy, done, err;

  int force_sel = 0;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  // Reference position of the counter, advanced by whole legs.
  int m_count = 0;
  bit m_dir = 1'b0;

  typedef struct {
    bit is_err;
    int cnt;
    int tgt;
    bit dir;
    int at_edge;
  } exp_t;
  exp_t sb_q[$];

  logic err_prev = 1'b0;

  tracking_counter #(.WIDTH(W), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .start(start), .target_in(target_in),
    .AgB(AgB), .AlB(AlB), .AeB(AeB),
    .count(count), .target(target), .dir(dir),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Comparator model; force_sel injects illegal or impossible flag patterns.
  always_comb begin
    AgB = (count > target);
    AlB = (count < target);
    AeB = (count == target);
    case (force_sel)
      1: {AgB, AlB, AeB} = 3'b101;
      2: {AgB, AlB, AeB} = 3'b010;
      3: {AgB, AlB, AeB} = 3'b100;
      default: ;
    endcase
  end

  function automatic void check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    err_prev <= err;
    if (!rst && (done || (err && !err_prev))) begin
      if (sb_q.size() == 0) begin
        check("event_expected", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        check("event_err",    int'(err),    int'(e.is_err));
        check("event_done",   int'(done),   int'(!e.is_err));
        check("event_cycle",  cyc,          e.at_edge);
        check("event_count",  int'(count),  e.cnt);
        check("event_target", int'(target), e.tgt);
        check("event_dir",    int'(dir),    int'(e.dir));
        check("event_busy",   int'(busy),   0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; start is sampled by edge e0.
  task automatic launch(input int tgt, output int e0);
    start     = 1'b1;
    target_in = W'(tgt);
    e0        = cyc + 1;
    tick(1);
    start = 1'b0;
  endtask

  // Uninterrupted approach: done follows |d| steps, the match edge and HOLD edges.
  task automatic finish_leg(input int tgt, input int e0);
    int d;
    d = iabs(tgt - m_count);
    if (tgt != m_count) m_dir = (tgt > m_count);
    m_count = tgt;
    sb_q.push_back('{1'b0, tgt, tgt, m_dir, e0 + d + H + 1});
    tick(d + H + 2);
  endtask

  task automatic leg(input int tgt);
    int e0;
    launch(tgt, e0);
    finish_leg(tgt, e0);
  endtask

  // Count position just before edge e0+k of a leg toward t1.
  task automatic advance_model(input int t1, input int k);
    int s;
    s = imin(k - 1, iabs(t1 - m_count));
    if (s > 0) begin
      m_dir   = (t1 > m_count);
      m_count = m_dir ? m_count + s : m_count - s;
    end
  endtask

  task automatic retarget_leg(input int t1, input int k, input int t2);
    int e0, e1;
    launch(t1, e0);
    advance_model(t1, k);
    tick(k - 1);
    launch(t2, e1);
    finish_leg(t2, e1);
  endtask

  task automatic err_leg(input int t1, input int k, input int t2);
    int e0;
    launch(t1, e0);
    advance_model(t1, k);
    tick(k - 1);
    sb_q.push_back('{1'b1, m_count, t1, m_dir, e0 + k});
    force_sel = 1;
    tick(1);
    force_sel = 0;
    tick(3);
    check("err_frozen_count", int'(count), m_count);
    check("err_sticky", int'(err), 1);
    leg(t2);
  endtask

  // Forces a step request off the end of the range from a settled count.
  task automatic boundary_err(input int fsel);
    int e0;
    launch(m_count, e0);
    sb_q.push_back('{1'b1, m_count, m_count, m_dir, e0 + 1});
    force_sel = fsel;
    tick(1);
    force_sel = 0;
    tick(2);
    check("boundary_count", int'(count), m_count);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_count"},  int'(count),  0);
    check({tag, "_target"}, int'(target), 0);
    check({tag, "_dir"},    int'(dir),    0);
    check({tag, "_busy"},   int'(busy),   0);
    check({tag, "_done"},   int'(done),   0);
    check({tag, "_err"},    int'(err),    0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int e0, t1, t2, k, mode;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check_reset("rst");

    leg(6);
    leg(2);
    retarget_leg(15, 8, 3);
    err_leg(12, 3, 0);

    launch(15, e0);
    tick(5);
    check("midrst_pre_count", int'(count), 5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_reset("midrst");
    m_count = 0;
    m_dir   = 1'b0;
    leg(0);

    leg(15);
    boundary_err(2);
    leg(0);
    boundary_err(3);
    leg(0);

    for (int i = 0; i < 16; i++) begin
      mode = $urandom_range(0, 2);
      t1   = $urandom_range(0, 15);
      t2   = $urandom_range(0, 15);
      if (mode == 0) begin
        leg(t1);
      end else if (mode == 1) begin
        k = $urandom_range(1, iabs(t1 - m_count) + H);
        retarget_leg(t1, k, t2);
      end else begin
        t1 = (m_count + 1 + $urandom_range(0, 14)) % 16;
        k  = $urandom_range(1, iabs(t1 - m_count) + 1);
        err_leg(t1, k, t2);
      end
    end

    tick(4);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
